// File: rtl/autoplay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_pkg
// Purpose  : Shared types and helpers for the ROM-driven auto-player.
//            - state_t : sequencer state encoding
//            - note_lsb / dur_lsb : bit offsets of the fields in a
//              {dur, note} ROM entry
// Revision : 1.0 - initial release
// ============================================================================
package autoplay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    // The note code occupies the low bits of an entry.
    function automatic int note_lsb();
        return 0;
    endfunction

    // The duration sits directly above the note code.
    function automatic int dur_lsb(input int msg_w);
        return msg_w;
    endfunction

endpackage : autoplay_pkg
`default_nettype wire

// File: rtl/autoplay_if.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_if
// Purpose  : Song-ROM read port and note-message output bus of the player.
//            rom_addr  : entry address (player -> ROM)
//            rom_data  : {dur, note}, valid one cycle after rom_addr
//            msg_valid : note message available (player -> consumer)
//            msg_ready : consumer accepts the message
//            msg       : note code
//            master = player side, slave = ROM / consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface autoplay_if #(
    parameter int MSG_W  = 8,
    parameter int DUR_W  = 8,
    parameter int ADDR_W = 11
) ();

    logic [ADDR_W-1:0]      rom_addr;
    logic [DUR_W+MSG_W-1:0] rom_data;
    logic                   msg_valid;
    logic                   msg_ready;
    logic [MSG_W-1:0]       msg;

    modport master (
        output rom_addr,
        input  rom_data,
        output msg_valid,
        input  msg_ready,
        output msg
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  msg_valid,
        output msg_ready,
        input  msg
    );

endinterface : autoplay_if
`default_nettype wire

// File: rtl/autoplay_timer.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_timer
// Purpose  : Per-entry delay timer. Loads a target, counts qualified ticks
//            (tick high, pause low, enabled) and flags cnt >= target.
// Ports    : clk_play, rst (async, active-high)
//            load_i    : load target_i and clear the count
//            target_i  : delay in ticks
//            en_i      : counting window (sequencer waiting)
//            tick_i    : 1 kHz enable
//            pause_i   : freeze counting; ticks seen while paused are lost
//            reached_o : count has reached the target
// Revision : 1.0 - initial release
// ============================================================================
module autoplay_timer #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk_play,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] target_i,
    input  wire logic             en_i,
    input  wire logic             tick_i,
    input  wire logic             pause_i,
    output logic                  reached_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;

    assign reached_o = (cnt_q >= target_q);

    // Counting stops once the target is reached, so cnt never passes target
    // and the counter cannot wrap.
    always_comb begin
        cnt_d    = cnt_q;
        target_d = target_q;
        if (load_i) begin
            target_d = target_i;
            cnt_d    = '0;
        end else if (en_i && tick_i && !pause_i && !reached_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_play or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

endmodule : autoplay_timer
`default_nettype wire

// File: rtl/autoplay_seq.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_seq
// Purpose  : Steps through a song in an external synchronous ROM and emits
//            one note message per entry after a delay of dur*tempo ms ticks.
//            Supports start/stop, pause, loop or one-shot playback.
// Ports    : clk_play, rst (async, active-high)
//            tick_i    : 1 kHz single-cycle enable
//            start_i   : begin playback from index 0 (idle only)
//            stop_i    : abort playback, drop any pending message
//            pause_i   : freeze delay counting while high
//            loop_en_i : wrap at end of song instead of finishing
//            tempo_i   : ms per duration unit, sampled per entry
//            bus       : ROM read port and message handshake (master)
//            busy_o    : high in any state except idle
//            done_o    : one-cycle pulse at the end of a one-shot song
// Revision : 1.0 - initial release
// ============================================================================
module autoplay_seq
    import autoplay_pkg::*;
#(
    parameter int MSG_W    = 8,
    parameter int DUR_W    = 8,
    parameter int TEMPO_W  = 8,
    parameter int ADDR_W   = 11,
    parameter int SONG_LEN = 1394
) (
    input  wire logic               clk_play,
    input  wire logic               rst,
    input  wire logic               tick_i,
    input  wire logic               start_i,
    input  wire logic               stop_i,
    input  wire logic               pause_i,
    input  wire logic               loop_en_i,
    input  wire logic [TEMPO_W-1:0] tempo_i,
    autoplay_if.master              bus,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int                CNT_W    = DUR_W + TEMPO_W;
    localparam int                NOTE_LSB = note_lsb();
    localparam int                DUR_LSB  = dur_lsb(MSG_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [MSG_W-1:0]  note_q;
    logic [MSG_W-1:0]  msg_q;
    logic              valid_q;
    logic              done_q;

    logic [DUR_W-1:0]  w_dur;
    logic [MSG_W-1:0]  w_note;
    logic [CNT_W-1:0]  w_target;
    logic              w_reached;

    assign w_dur  = bus.rom_data[DUR_LSB +: DUR_W];
    assign w_note = bus.rom_data[NOTE_LSB +: MSG_W];

    // Both operands are widened to the full product width so dur*tempo
    // is never truncated.
    assign w_target = {{TEMPO_W{1'b0}}, w_dur} * {{DUR_W{1'b0}}, tempo_i};

    autoplay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_play  (clk_play),
        .rst       (rst),
        .load_i    (state_q == ST_LATCH),
        .target_i  (w_target),
        .en_i      (state_q == ST_WAIT),
        .tick_i    (tick_i),
        .pause_i   (pause_i),
        .reached_o (w_reached)
    );

    always_ff @(posedge clk_play or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (stop_i) begin
            // Stop wins over start and over a handshake completing in the
            // same cycle; the pending message is dropped silently.
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        idx_q   <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    note_q  <= w_note;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_reached) begin
                        msg_q   <= note_q;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // valid_q is always high in this state.
                    if (bus.msg_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (loop_en_i) begin
                                state_q <= ST_FETCH;
                            end else begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr  = idx_q;
    assign bus.msg_valid = valid_q;
    assign bus.msg       = msg_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule : autoplay_seq
`default_nettype wire

// File: tb/tb_autoplay_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_autoplay_seq
// Purpose  : Self-checking bench for autoplay_seq with a 3-entry song.
//            Directed scenarios followed by a randomized run against a
//            timing model written from the player's rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_autoplay_seq;

    localparam int MSG_W    = 8;
    localparam int DUR_W    = 8;
    localparam int TEMPO_W  = 8;
    localparam int ADDR_W   = 4;
    localparam int SONG_LEN = 3;

    logic               clk_play = 1'b0;
    logic               rst      = 1'b0;
    logic               tick     = 1'b0;
    logic               start    = 1'b0;
    logic               stop     = 1'b0;
    logic               pause    = 1'b0;
    logic               loop_en  = 1'b0;
    logic [TEMPO_W-1:0] tempo    = 8'd1;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    logic [DUR_W+MSG_W-1:0] rom [16];

    autoplay_if #(.MSG_W(MSG_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus ();

    autoplay_seq #(
        .MSG_W    (MSG_W),
        .DUR_W    (DUR_W),
        .TEMPO_W  (TEMPO_W),
        .ADDR_W   (ADDR_W),
        .SONG_LEN (SONG_LEN)
    ) u_dut (
        .clk_play  (clk_play),
        .rst       (rst),
        .tick_i    (tick),
        .start_i   (start),
        .stop_i    (stop),
        .pause_i   (pause),
        .loop_en_i (loop_en),
        .tempo_i   (tempo),
        .bus       (bus),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk_play = ~clk_play;

    // Synchronous song ROM: data valid one cycle after the address.
    always @(posedge clk_play) bus.rom_data <= rom[bus.rom_addr];

    task automatic cyc();
        @(posedge clk_play);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (bus.rom_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.rom_addr); end
        total++; if (bus.msg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.msg_valid); end
        total++; if (bus.msg !== 8'h00) begin bad++; $display("FAIL reset_msg got=%0h exp=0", bus.msg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // Zero-delay one-shot song: k+3 latency, 4-cycle throughput, done pulse.
    task automatic test_latency();
        logic [7:0] notes [3];
        notes[0] = 8'h3C; notes[1] = 8'h41; notes[2] = 8'h43;
        for (int i = 0; i < 3; i++) rom[i] = {8'h00, notes[i]};
        loop_en = 1'b0; bus.msg_ready = 1'b1; tempo = 8'd5;
        start = 1'b1; cyc(); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%0b exp=1", busy); end
        for (int j = 0; j < 3; j++) begin
            cyc();
            total++; if (bus.msg_valid !== 1'b0) begin bad++; $display("FAIL lat_early1 j=%0d got=%0b exp=0", j, bus.msg_valid); end
            cyc();
            total++; if (bus.msg_valid !== 1'b0) begin bad++; $display("FAIL lat_early2 j=%0d got=%0b exp=0", j, bus.msg_valid); end
            cyc();
            total++;
            if ({bus.msg_valid, bus.msg, bus.rom_addr} !== {1'b1, notes[j], 4'(j)}) begin
                bad++; $display("FAIL lat_emit j=%0d got v=%0b m=%0h a=%0d exp v=1 m=%0h a=%0d",
                                j, bus.msg_valid, bus.msg, bus.rom_addr, notes[j], j);
            end
            cyc();
            total++;
            if (j == 2) begin
                if ({done, busy, bus.msg_valid, bus.rom_addr} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
                    bad++; $display("FAIL lat_end got done=%0b busy=%0b v=%0b a=%0d exp 1 0 0 0",
                                    done, busy, bus.msg_valid, bus.rom_addr);
                end
            end else begin
                if ({done, bus.rom_addr} !== {1'b0, 4'(j + 1)}) begin
                    bad++; $display("FAIL lat_next j=%0d got done=%0b a=%0d exp done=0 a=%0d",
                                    j, done, bus.rom_addr, j + 1);
                end
            end
        end
        cyc();
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL lat_done_len got done=%0b busy=%0b exp 0 0", done, busy); end
    endtask

    // dur=4, tempo=9: 36 counted ticks; a 10-tick pause window extends it.
    task automatic test_tempo_pause();
        int  raw  = 0;
        int  qual = 0;
        bit  seen = 0;
        rom[0] = {8'd4, 8'h50};
        tempo = 8'd9; bus.msg_ready = 1'b0; tick = 1'b0; pause = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();                   // latch edge samples tempo=9 next
        cyc();
        tempo = 8'd1;            // must not affect the entry already latched
        for (int i = 0; i < 400 && !seen; i++) begin
            tick  = (i % 2 == 0);
            pause = (raw >= 10 && raw < 20);
            cyc();
            if (bus.msg_valid === 1'b1) seen = 1;
            else begin
                if (tick) raw++;
                if (tick && !pause) qual++;
            end
        end
        tick = 1'b0; pause = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL tempo_timeout got=%0b exp=1", seen); end
        total++; if (qual !== 36) begin bad++; $display("FAIL tempo_ticks got=%0d exp=36", qual); end
        total++; if (raw !== 46) begin bad++; $display("FAIL tempo_raw_ticks got=%0d exp=46", raw); end
        total++; if (bus.msg !== 8'h50) begin bad++; $display("FAIL tempo_msg got=%0h exp=50", bus.msg); end
    endtask

    // Held in SEND with msg_ready low: everything stable, then accepted.
    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            tick  = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            cyc();
            total++;
            if ({bus.msg_valid, bus.msg, bus.rom_addr} !== {1'b1, 8'h50, 4'd0}) begin
                bad++; $display("FAIL hold_stable i=%0d got v=%0b m=%0h a=%0d exp v=1 m=50 a=0",
                                i, bus.msg_valid, bus.msg, bus.rom_addr);
            end
        end
        tick = 1'b0; pause = 1'b0;
        bus.msg_ready = 1'b1;
        cyc();
        total++;
        if ({bus.msg_valid, bus.rom_addr} !== {1'b0, 4'd1}) begin
            bad++; $display("FAIL hold_accept got v=%0b a=%0d exp v=0 a=1", bus.msg_valid, bus.rom_addr);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_stop_busy got=%0b exp=0", busy); end
    endtask

    // Loop mode wraps without done; clearing loop_en on the last entry ends it.
    task automatic test_loop();
        int         n = 0;
        logic [3:0] exp_addr [6];
        exp_addr[0] = 4'd0; exp_addr[1] = 4'd1; exp_addr[2] = 4'd2;
        exp_addr[3] = 4'd0; exp_addr[4] = 4'd1; exp_addr[5] = 4'd2;
        for (int i = 0; i < 3; i++) rom[i] = {8'h00, 8'(8'h60 + i)};
        bus.msg_ready = 1'b1; loop_en = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 100 && n < 6; i++) begin
            cyc();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_done_early i=%0d got=%0b exp=0", i, done); end
            if (bus.msg_valid === 1'b1) begin
                total++;
                if (bus.rom_addr !== exp_addr[n]) begin
                    bad++; $display("FAIL loop_addr n=%0d got=%0d exp=%0d", n, bus.rom_addr, exp_addr[n]);
                end
                if (n == 5) loop_en = 1'b0;
                n++;
            end
        end
        total++; if (n !== 6) begin bad++; $display("FAIL loop_timeout got=%0d exp=6", n); end
        cyc();
        total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL loop_end got done=%0b busy=%0b exp 1 0", done, busy); end
    endtask

    // Stop with a handshake completing in the same cycle drops the message.
    task automatic test_stop();
        for (int i = 0; i < 3; i++) rom[i] = {8'h00, 8'(8'h70 + i)};
        bus.msg_ready = 1'b1; loop_en = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (7) cyc();
        total++;
        if ({bus.msg_valid, bus.rom_addr} !== {1'b1, 4'd1}) begin
            bad++; $display("FAIL stop_pre got v=%0b a=%0d exp v=1 a=1", bus.msg_valid, bus.rom_addr);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        total++;
        if ({bus.msg_valid, busy, bus.rom_addr, done} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL stop_state got v=%0b busy=%0b a=%0d done=%0b exp 0 0 0 0",
                            bus.msg_valid, busy, bus.rom_addr, done);
        end
        cyc();
        total++; if ({done, busy, bus.msg_valid} !== 3'b000) begin bad++; $display("FAIL stop_after got done=%0b busy=%0b v=%0b exp 0 0 0", done, busy, bus.msg_valid); end
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_over_start got=%0b exp=0", busy); end
    endtask

    // Asynchronous reset mid-wait, then a replay from index 0.
    task automatic test_async_reset();
        rom[0] = {8'h00, 8'h3C};
        rom[1] = {8'd10, 8'h11};
        tempo = 8'd10; bus.msg_ready = 1'b1; tick = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (8) cyc();
        total++;
        if ({busy, bus.rom_addr, bus.msg_valid} !== {1'b1, 4'd1, 1'b0}) begin
            bad++; $display("FAIL arst_pre got busy=%0b a=%0d v=%0b exp 1 1 0", busy, bus.rom_addr, bus.msg_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, bus.rom_addr, bus.msg_valid, bus.msg, done} !== {1'b0, 4'd0, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("FAIL arst_async got busy=%0b a=%0d v=%0b m=%0h done=%0b exp 0 0 0 0 0",
                            busy, bus.rom_addr, bus.msg_valid, bus.msg, done);
        end
        cyc();
        rst = 1'b0; tick = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        total++;
        if ({bus.msg_valid, bus.msg, bus.rom_addr} !== {1'b1, 8'h3C, 4'd0}) begin
            bad++; $display("FAIL arst_replay got v=%0b m=%0h a=%0d exp v=1 m=3c a=0",
                            bus.msg_valid, bus.msg, bus.rom_addr);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    // Randomized run against a model that times each entry from the edge
    // that started it: tempo is taken two edges later, and the message
    // appears once the required number of unpaused ticks has been seen
    // from the third edge on.
    task automatic test_random();
        bit         m_busy  = 0;
        bit         m_valid = 0;
        bit         m_done  = 0;
        int         m_idx   = 0;
        int         m_age   = 0;
        int         m_need  = 0;
        int         m_got   = 0;
        logic [7:0] m_msg   = 8'h00;
        logic [7:0] m_note  = 8'h00;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) rom[i] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            rst = 1'b1; cyc(); rst = 1'b0;
            m_busy = 0; m_valid = 0; m_done = 0; m_idx = 0; m_age = 0; m_msg = 8'h00;
            for (int c = 0; c < 800; c++) begin
                start         = ($urandom_range(0, 19) == 0);
                stop          = ($urandom_range(0, 59) == 0);
                tick          = 1'($urandom_range(0, 1));
                pause         = ($urandom_range(0, 3) == 0);
                bus.msg_ready = ($urandom_range(0, 2) != 0);
                tempo         = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
                cyc();
                m_done = 0;
                if (stop) begin
                    m_busy = 0; m_valid = 0; m_idx = 0;
                end else if (!m_busy) begin
                    if (start) begin m_busy = 1; m_idx = 0; m_age = 0; end
                end else if (m_valid) begin
                    if (bus.msg_ready) begin
                        m_valid = 0;
                        m_age   = 0;
                        if (m_idx == SONG_LEN - 1) begin
                            m_idx = 0;
                            if (!loop_en) begin m_busy = 0; m_done = 1; end
                        end else begin
                            m_idx++;
                        end
                    end
                end else begin
                    if (m_age < 3) m_age++;
                    if (m_age == 2) begin
                        m_need = int'(rom[m_idx][15:8]) * int'(tempo);
                        m_note = rom[m_idx][7:0];
                        m_got  = 0;
                    end else if (m_age == 3) begin
                        if (m_got >= m_need) begin m_valid = 1; m_msg = m_note; end
                        else if (tick && !pause) m_got++;
                    end
                end
                total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_busy); end
                total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done c=%0d got=%0b exp=%0b", c, done, m_done); end
                total++; if (bus.rom_addr !== 4'(m_idx)) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, bus.rom_addr, m_idx); end
                total++; if (bus.msg_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, bus.msg_valid, m_valid); end
                if (m_valid) begin
                    total++; if (bus.msg !== m_msg) begin bad++; $display("FAIL rnd_msg c=%0d got=%0h exp=%0h", c, bus.msg, m_msg); end
                end
            end
        end
        start = 1'b0; stop = 1'b0; tick = 1'b0; pause = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        bus.msg_ready = 1'b1;
        test_reset();
        test_latency();
        test_tempo_pause();
        test_hold();
        test_loop();
        test_stop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_autoplay_seq
`default_nettype wire
